// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the opcode decoder.
// Walks pc through byte-wide memory, fetches the opcode plus 0-2 operand
// bytes sized by the decoder, and holds the instruction under valid/ready.
// Optional feature: define FETCH_RESET_VECTOR_EN to load the start pc from
// the reset vector at 16'hFFFC/16'hFFFD instead of using RESET_PC.
module fetch_unit #(
  parameter logic [15:0] RESET_PC   = 16'h0200,
  parameter logic [7:0]  NOP_OPCODE = 8'hEA
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  input  logic [1:0]  instr_size,
  output logic [7:0]  opcode,
  output logic [7:0]  operand_lo,
  output logic [7:0]  operand_hi,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        jump_en,
  input  logic [15:0] jump_target
);

  typedef enum logic [2:0] {
    FETCH_OP,
    SIZE,
    FETCH_B1,
    FETCH_B2,
    VALID
`ifdef FETCH_RESET_VECTOR_EN
    , VEC_LO,
    VEC_HI
`endif
  } state_t;

`ifdef FETCH_RESET_VECTOR_EN
  localparam state_t START_STATE = VEC_LO;
`else
  localparam state_t START_STATE = FETCH_OP;
`endif

  state_t      state_q, state_d;
  logic [15:0] pc_q;
  logic        req_c;
  logic [15:0] addr_c;
  logic        fire;
  logic [1:0]  eff_size;

  // An out-of-range size of 0 is handled as a 1-byte instruction.
  assign eff_size = (instr_size == 2'd0) ? 2'd1 : instr_size;
  assign fire     = req_c && mem_ack;

  // Request and address decode purely from registered state; reset forces
  // the request low even though the start state itself is a fetch state.
  assign mem_req     = req_c && rst_n;
  assign mem_addr    = rst_n ? addr_c : pc_q;
  assign instr_valid = (state_q == VALID);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    if (!rst_n) state_q <= START_STATE;
    else        state_q <= state_d;
  end

  // Next-state and memory request decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d = state_q;
    req_c   = 1'b0;
    addr_c  = pc_q;
    case (state_q)
      FETCH_OP: begin
        req_c = 1'b1;
        if (mem_ack) state_d = SIZE;
      end
      SIZE:     state_d = (eff_size >= 2'd2) ? FETCH_B1 : VALID;
      FETCH_B1: begin
        req_c = 1'b1;
        if (mem_ack) state_d = (eff_size == 2'd3) ? FETCH_B2 : VALID;
      end
      FETCH_B2: begin
        req_c = 1'b1;
        if (mem_ack) state_d = VALID;
      end
      VALID:    if (instr_ready) state_d = FETCH_OP;
`ifdef FETCH_RESET_VECTOR_EN
      VEC_LO: begin
        req_c  = 1'b1;
        addr_c = 16'hFFFC;
        if (mem_ack) state_d = VEC_HI;
      end
      VEC_HI: begin
        req_c  = 1'b1;
        addr_c = 16'hFFFD;
        if (mem_ack) state_d = FETCH_OP;
      end
`endif
      default:  state_d = START_STATE;
    endcase
  end

`ifdef FETCH_RESET_VECTOR_EN
  logic [7:0] vec_lo_q;

  // Holds the low vector byte until the high byte arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     vec_lo_q <= 8'h00;
    else if (state_q == VEC_LO && fire) vec_lo_q <= mem_rdata;
  end
`endif

  // Program counter and instruction holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      opcode     <= NOP_OPCODE;
      operand_lo <= 8'h00;
      operand_hi <= 8'h00;
      instr_pc   <= 16'h0000;
    end else begin
      case (state_q)
        FETCH_OP: if (fire) begin
          opcode     <= mem_rdata;
          instr_pc   <= pc_q;
          operand_lo <= 8'h00;
          operand_hi <= 8'h00;
          pc_q       <= pc_q + 16'd1;
        end
        FETCH_B1: if (fire) begin
          operand_lo <= mem_rdata;
          pc_q       <= pc_q + 16'd1;
        end
        FETCH_B2: if (fire) begin
          operand_hi <= mem_rdata;
          pc_q       <= pc_q + 16'd1;
        end
        VALID:    if (instr_ready && jump_en) pc_q <= jump_target;
`ifdef FETCH_RESET_VECTOR_EN
        VEC_HI:   if (fire) pc_q <= {mem_rdata, vec_lo_q};
`endif
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus a randomized run for fetch_unit.
// A byte memory, a small decoder size table and a per-instruction reference
// model feed a scoreboard queue; a separate monitor pops and compares on
// every valid/ready handshake and checks request and output stability.
module tb_fetch_unit;

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [15:0] pc;
  } exp_t;

`ifdef FETCH_RESET_VECTOR_EN
  localparam logic [15:0] BASE = 16'h8000;
  localparam int          VEC_CYCLES = 2;
`else
  localparam logic [15:0] BASE = 16'h0200;
  localparam int          VEC_CYCLES = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [1:0]  instr_size;
  logic [7:0]  opcode, operand_lo, operand_hi;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump_en;
  logic [15:0] jump_target;

  logic [7:0]  mem [0:65535];
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          rand_ack = 1'b0;
  logic [15:0] stall_addr = 16'h0000;
  int          stall_cnt = 0;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_size(instr_size),
    .opcode(opcode), .operand_lo(operand_lo), .operand_hi(operand_hi),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .jump_en(jump_en), .jump_target(jump_target)
  );

  always #5 clk = ~clk;

  // Decoder stand-in: a few known opcodes, otherwise the low two bits.
  function automatic logic [1:0] size_of(input logic [7:0] op);
    case (op)
      8'hA9:   return 2'd2;
      8'hE8:   return 2'd1;
      8'h4C:   return 2'd3;
      default: return op[1:0];
    endcase
  endfunction

  assign instr_size = size_of(opcode);
  assign mem_rdata  = mem[mem_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the instruction found at an address, by size rules.
  function automatic exp_t predict(input logic [15:0] at, output int len);
    exp_t e;
    int   s;
    e.op = mem[at];
    s    = int'(size_of(e.op));
    if (s == 0) s = 1;
    e.lo = (s >= 2) ? mem[at + 16'd1] : 8'h00;
    e.hi = (s == 3) ? mem[at + 16'd2] : 8'h00;
    e.pc = at;
    len  = s;
    return e;
  endfunction

  function automatic exp_t mk(input logic [7:0] op, lo, hi, input logic [15:0] pc);
    exp_t e;
    e.op = op; e.lo = lo; e.hi = hi; e.pc = pc;
    return e;
  endfunction

  // Memory responder: zero-wait, random waits, or a forced stall window.
  initial forever begin
    @(negedge clk);
    #1;
    if (mem_req && mem_addr == stall_addr && stall_cnt > 0) begin
      mem_ack = 1'b0;
      stall_cnt--;
    end else if (rand_ack) begin
      mem_ack = ($urandom_range(0, 3) != 0);
    end else begin
      mem_ack = 1'b1;
    end
  end

  // Monitor: scoreboard pops on handshake, stability of stalled requests
  // and of a held instruction.
  logic        p_stall, p_hold;
  logic [15:0] p_addr, p_ipc;
  logic [7:0]  p_op, p_lo, p_hi;
  initial begin
    p_stall = 1'b0;
    p_hold  = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        p_stall = 1'b0;
        p_hold  = 1'b0;
      end else begin
        if (p_stall) check("req_stable", {mem_req, mem_addr}, {1'b1, p_addr});
        if (p_hold)
          check("instr_frozen", {instr_valid, opcode, operand_lo, operand_hi, instr_pc},
                {1'b1, p_op, p_lo, p_hi, p_ipc});
        if (instr_valid && instr_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_instr: got opcode %h at %h expected none", opcode, instr_pc);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("instr", {opcode, operand_lo, operand_hi, instr_pc}, {e.op, e.lo, e.hi, e.pc});
          end
        end
        p_stall = mem_req && !mem_ack;
        p_addr  = mem_addr;
        p_hold  = instr_valid && !instr_ready;
        p_op    = opcode;
        p_lo    = operand_lo;
        p_hi    = operand_hi;
        p_ipc   = instr_pc;
      end
    end
  end

  task automatic wait_valid();
    int n = 0;
    while (!instr_valid && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!instr_valid) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: got no instr_valid expected one within 100 cycles");
    end
  endtask

  task automatic handshake(input logic jen, input logic [15:0] jt);
    wait_valid();
    instr_ready = 1'b1;
    jump_en     = jen;
    jump_target = jt;
    @(negedge clk);
    #1;
    instr_ready = 1'b0;
    jump_en     = 1'b0;
  endtask

  task automatic count_to_valid(output int n);
    n = 0;
    while (!instr_valid && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int          n;
    int          len;
    logic [15:0] pc_m;
    rst_n = 1'b0; instr_ready = 1'b0; jump_en = 1'b0; jump_target = 16'h0000; mem_ack = 1'b0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
    mem[BASE] = 8'hA9; mem[BASE + 16'd1] = 8'h42; mem[BASE + 16'd2] = 8'hE8;
    mem[BASE + 16'd3] = 8'h4C; mem[BASE + 16'd4] = 8'h00; mem[BASE + 16'd5] = 8'h30;
    mem[16'h3000] = 8'hA9; mem[16'h3001] = 8'h77;
    mem[16'h3002] = 8'h4C; mem[16'h3003] = 8'hFE; mem[16'h3004] = 8'hFF;
    mem[16'hFFFE] = 8'h4C; mem[16'hFFFF] = 8'h11; mem[16'h0000] = 8'h22;
    mem[16'h0001] = 8'hA9; mem[16'h0002] = 8'h55;

    // Reset values.
    repeat (2) @(negedge clk);
    #1;
    check("reset_req_valid", {mem_req, instr_valid}, 2'b00);
    check("reset_instr", {opcode, operand_lo, operand_hi, instr_pc}, {8'hEA, 8'h00, 8'h00, 16'h0000});
    check("reset_addr", mem_addr, 16'h0200);

    // First instruction latency after reset release.
    rst_n = 1'b1;
    count_to_valid(n);
    check("latency_2byte", n, 3 + VEC_CYCLES);

    exp_q.push_back(mk(8'hA9, 8'h42, 8'h00, BASE));
    handshake(1'b0, 16'h0000);
    check("next_addr_after_lda", {mem_req, mem_addr}, {1'b1, BASE + 16'd2});
    exp_q.push_back(mk(8'hE8, 8'h00, 8'h00, BASE + 16'd2));
    handshake(1'b0, 16'h0000);
    exp_q.push_back(mk(8'h4C, 8'h00, 8'h30, BASE + 16'd3));
    handshake(1'b1, 16'h3000);
    check("jump_redirect", {mem_req, mem_addr}, {1'b1, 16'h3000});

    // Three wait states on the operand fetch.
    stall_addr = 16'h3001;
    stall_cnt  = 3;
    count_to_valid(n);
    check("latency_stalled", n, 6);

    // Held in VALID with jump_en toggling while not ready.
    exp_q.push_back(mk(8'hA9, 8'h77, 8'h00, 16'h3000));
    for (int i = 0; i < 5; i++) begin
      jump_en     = (i % 2 == 0);
      jump_target = 16'h1234;
      @(negedge clk);
      #1;
      check("hold_no_req", {mem_req, instr_valid}, 2'b01);
    end
    jump_en = 1'b0;
    handshake(1'b0, 16'h0000);
    check("no_redirect_when_not_ready", {mem_req, mem_addr}, {1'b1, 16'h3002});

    // 3-byte instruction across the address wrap.
    exp_q.push_back(mk(8'h4C, 8'hFE, 8'hFF, 16'h3002));
    handshake(1'b1, 16'hFFFE);
    exp_q.push_back(mk(8'h4C, 8'h11, 8'h22, 16'hFFFE));
    handshake(1'b0, 16'h0000);
    check("wrap_next_addr", {mem_req, mem_addr}, {1'b1, 16'h0001});

    // Reset asserted mid operand fetch.
    stall_addr = 16'h0002;
    stall_cnt  = 5;
    n = 0;
    while (!(mem_req && mem_addr == 16'h0002) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("reached_operand_fetch", {mem_req, mem_addr}, {1'b1, 16'h0002});
    rst_n = 1'b0;
    #1;
    check("midreset_req_valid", {mem_req, instr_valid}, 2'b00);
    check("midreset_instr", {opcode, operand_lo, operand_hi, instr_pc, mem_addr},
          {8'hEA, 8'h00, 8'h00, 16'h0000, 16'h0200});
    stall_cnt = 0;

    // Randomized program, random waits, random ready delays and jumps.
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
    rand_ack = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    pc_m  = BASE;
    for (int i = 0; i < 120; i++) begin
      logic        jen;
      logic [15:0] jt;
      exp_q.push_back(predict(pc_m, len));
      jen = ($urandom_range(0, 3) == 0);
      jt  = 16'($urandom);
      wait_valid();
      repeat ($urandom_range(0, 3)) begin
        jump_en     = 1'($urandom);
        jump_target = 16'($urandom);
        @(negedge clk);
        #1;
      end
      handshake(jen, jt);
      pc_m = jen ? jt : pc_m + 16'(len);
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the opcode decoder. It walks the program counter through byte-wide memory, fetches the opcode, and uses the decoder's `instr_size` to fetch 0–2 operand bytes. It then presents the assembled instruction to the execute stage under a valid/ready handshake. On retirement it applies jump redirects from execute.

## Interface
Parameters:
- `RESET_PC`, 16'h0200, start address when the reset vector fetch is compiled out.
- `NOP_OPCODE`, 8'hEA, value driven on `opcode` while idle or in reset.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `mem_req`  output  1  read request; `mem_addr` is held stable while high.
- `mem_addr`  output  16  byte address of the current request.
- `mem_ack`  input  1  request accepted; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  input  8  read data.
- `instr_size`  input  2  from the decoder, combinational on `opcode`; legal values are 1, 2 or 3.
- `opcode`  output  8  registered opcode; feeds the decoder.
- `operand_lo`  output  8  first operand byte; 0 if absent.
- `operand_hi`  output  8  second operand byte; 0 if absent.
- `instr_pc`  output  16  address of the opcode of the held instruction.
- `instr_valid`  output  1  instruction complete and held stable.
- `instr_ready`  input  1  execute consumes the instruction.
- `jump_en`  input  1  redirect; sampled only on the handshake.
- `jump_target`  input  16  redirect address.

## Operation
- Internal 16-bit `pc`: the next byte to fetch. It increments by 1 on every `mem_ack` and wraps from 16'hFFFF to 16'h0000.
- States:
  - VEC_LO, VEC_HI: only when the configuration macro is defined.
  - FETCH_OP: `mem_req`=1, `mem_addr`=`pc`. On `mem_ack`: latch `opcode`, set `instr_pc`=`pc`, clear both operands, then go to SIZE.
  - SIZE: `mem_req`=0. The decoder output for the new opcode is now stable. Next state is FETCH_B1 if `instr_size`≥2, otherwise VALID.
  - FETCH_B1: on `mem_ack`, latch `operand_lo`. Next state is FETCH_B2 if `instr_size`==3, otherwise VALID.
  - FETCH_B2: on `mem_ack`, latch `operand_hi`, then go to VALID.
  - VALID: `instr_valid`=1. `opcode`, the operands and `instr_pc` are frozen. On `instr_ready`, `pc` is set to `jump_en ? jump_target : pc`, then go to FETCH_OP.
- If `instr_size` is 0 (out of range), treat it as 1.
- `mem_ack` with `mem_req` low is ignored.
- `jump_en` and `jump_target` are ignored outside the VALID∧`instr_ready` cycle.
- Reset (asynchronous, in any state, including mid-request) sets:
  - `pc`=`RESET_PC`, `mem_addr`=`pc`
  - `opcode`=`NOP_OPCODE`, `operand_lo`=`operand_hi`=0
  - `instr_pc`=0, `instr_valid`=0, `mem_req`=0
  - The state leaves reset into VEC_LO or FETCH_OP, with no request issued in the reset cycle.
- Any half-fetched instruction at reset is discarded.

## Timing
- Zero-wait memory (`mem_ack` tied high) gives these request-to-valid latencies:
  - 1-byte instruction: 2 cycles (FETCH_OP, SIZE), then VALID.
  - 2-byte instruction: 3 cycles.
  - 3-byte instruction: 4 cycles.
- Each wait state adds 1 cycle to the affected fetch state.
- `instr_valid` rises in the cycle after the last `mem_ack`, or after SIZE for 1-byte instructions.
- `instr_valid` stays high until sampled with `instr_ready`; it drops in the following cycle.
- A new FETCH_OP request appears in the cycle after the handshake, at the redirected address if `jump_en` was set.
- `mem_addr` and `mem_req` are registered-state outputs; they never change while `mem_req`=1 and `mem_ack`=0.

## Configuration
- `FETCH_RESET_VECTOR_EN` defined:
  - After reset, VEC_LO requests 16'hFFFC and latches the low byte.
  - VEC_HI requests 16'hFFFD and latches the high byte.
  - `pc` is set to {hi,lo} and the state moves to FETCH_OP.
  - `RESET_PC` is ignored.
- Not defined: VEC_LO/VEC_HI do not exist; FETCH_OP starts at `RESET_PC` in the first cycle after reset release.

## Test plan
- Zero-wait memory holding A9 42 at 0x0200, `instr_ready`=1 → `instr_valid` 3 cycles after reset release with `opcode`=A9, `operand_lo`=42, `operand_hi`=0, `instr_pc`=0200; next request at 0202.
- E8 at 0x0200 followed by 4C 00 30 at 0x0201, with `jump_en`=1 on the JMP handshake → INX is valid with `pc`=0201. JMP is valid with `operand_lo`=00, `operand_hi`=30, then the next request goes to 0x3000.
- `mem_ack` held low for 3 cycles on an operand fetch → `mem_addr`/`mem_req` stay stable; latency grows by exactly 3 cycles.
- `instr_ready`=0 for 5 cycles in VALID → outputs frozen, no `mem_req`; `jump_en` pulsed while `instr_ready`=0 → no redirect.
- 3-byte opcode at 0xFFFE → operand bytes are read from FFFF and 0000; the next fetch is at 0001.
- `rst_n` asserted during FETCH_B1 → `mem_req`=0 and `instr_valid`=0 immediately. With `FETCH_RESET_VECTOR_EN`, vector bytes 00/80 at FFFC/FFFD make the first opcode fetch address 0x8000.
